// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO operator stack and the infix-to-postfix
// converter: default geometry and the operator code set.
package stack_pkg;

  localparam int unsigned STACK_WIDTH = 32;
  localparam int unsigned STACK_DEPTH = 16;

  // Operator codes stored on the stack by the converter.
  typedef enum logic [2:0] {
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4
  } op_code_e;

endpackage : stack_pkg

// File: rtl/lifo_stack_if.sv
// Push/pop strobe-acknowledge bus of the LIFO stack. The requester uses the
// master modport and the stack uses the slave modport.
interface lifo_stack_if #(
  parameter int unsigned WIDTH = 32
);

  logic             PUSH_STB;
  logic [WIDTH-1:0] PUSH_DAT;
  logic             POP_STB;
  logic [WIDTH-1:0] POP_DAT;
  logic             POP_ACK;
  logic             PUSH_ACK;

  modport master (
    output PUSH_STB,
    output PUSH_DAT,
    output POP_STB,
    input  POP_DAT,
    input  POP_ACK,
    input  PUSH_ACK
  );

  modport slave (
    input  PUSH_STB,
    input  PUSH_DAT,
    input  POP_STB,
    output POP_DAT,
    output POP_ACK,
    output PUSH_ACK
  );

endinterface : lifo_stack_if

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are never cleared by reset.
module stack_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on the rising edge when enabled.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: combinational view of the addressed word.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule : stack_mem

// File: rtl/lifo_stack.sv
// Parameterised synchronous LIFO stack with strobe/acknowledge push and pop.
// Holds the stack pointer, accept logic and ack registers; storage lives in
// stack_mem. Optional macro STACK_STATUS_EN adds FULL/EMPTY/LEVEL outputs.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RST,
`ifdef STACK_STATUS_EN
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
`endif
  lifo_stack_if.slave                bus
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);

  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_nxt;
  logic             full;
  logic             empty;
  logic [AW-1:0]    top_addr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic             push_acc;
  logic             pop_acc;
  logic [WIDTH-1:0] rd_data;
  logic             push_ack_q;
  logic             pop_ack_q;

  // Pointer decode: empty/full flags and the address of the current top.
  always_comb begin
    full     = (sp == SPW'(DEPTH));
    empty    = (sp == '0);
    top_addr = AW'(sp - SPW'(1));
  end

  // Accept logic: a simultaneous push+pop on a non-empty stack replaces the
  // top in place; on an empty stack it degrades to a plain push. Strobes on
  // a reset edge are discarded, including the memory write.
  always_comb begin
    we       = 1'b0;
    waddr    = AW'(sp);
    sp_nxt   = sp;
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    if (RST) begin
      if (bus.PUSH_STB && bus.POP_STB && !empty) begin
        we       = 1'b1;
        waddr    = top_addr;
        push_acc = 1'b1;
        pop_acc  = 1'b1;
      end else if (bus.PUSH_STB && !full) begin
        we       = 1'b1;
        sp_nxt   = sp + SPW'(1);
        push_acc = 1'b1;
      end else if (bus.POP_STB && !empty) begin
        sp_nxt   = sp - SPW'(1);
        pop_acc  = 1'b1;
      end
    end
  end

  // Pointer and ack registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sp         <= '0;
      push_ack_q <= 1'b0;
      pop_ack_q  <= 1'b0;
    end else begin
      sp         <= sp_nxt;
      push_ack_q <= push_acc;
      pop_ack_q  <= pop_acc;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.PUSH_DAT),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  // Output view: top of stack, forced to zero when empty.
  always_comb begin
    bus.POP_DAT  = empty ? '0 : rd_data;
    bus.POP_ACK  = pop_ack_q;
    bus.PUSH_ACK = push_ack_q;
  end

`ifdef STACK_STATUS_EN
  // Status outputs decoded straight from the pointer.
  always_comb begin
    FULL  = full;
    EMPTY = empty;
    LEVEL = sp;
  end
`endif

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=32, DEPTH=16).
module tb_lifo_stack;
  import stack_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef STACK_STATUS_EN
  logic       FULL;
  logic       EMPTY;
  logic [4:0] LEVEL;
`endif

  lifo_stack_if #(.WIDTH(32)) bus ();

  lifo_stack #(
    .WIDTH (32),
    .DEPTH (16)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
`ifdef STACK_STATUS_EN
    .FULL  (FULL),
    .EMPTY (EMPTY),
    .LEVEL (LEVEL),
`endif
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.PUSH_STB = 1'b0;
    bus.POP_STB  = 1'b0;
  endtask

  initial begin
    logic [31:0] words [3];
    words[0] = 32'(OP_ADD);
    words[1] = 32'(OP_SUB);
    words[2] = 32'(OP_MUL);

    bus.PUSH_DAT = '0;
    idle();

    // Reset with no strobes
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    check("rst_pop_dat", bus.POP_DAT, 32'd0);
    check("rst_push_ack", 32'(bus.PUSH_ACK), 32'd0);
    check("rst_pop_ack", 32'(bus.POP_ACK), 32'd0);
`ifdef STACK_STATUS_EN
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_level", 32'(LEVEL), 32'd0);
`endif
    bus.POP_STB = 1'b1;
    tick();
    check("empty_pop_ack", 32'(bus.POP_ACK), 32'd0);
    check("empty_pop_dat", bus.POP_DAT, 32'd0);
    idle();

    // Push 1, 2, 3 back-to-back
    bus.PUSH_STB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.PUSH_DAT = words[i];
      tick();
      check($sformatf("push%0d_ack", i + 1), 32'(bus.PUSH_ACK), 32'd1);
      check($sformatf("push%0d_dat", i + 1), bus.POP_DAT, 32'(i + 1));
    end
    idle();
    tick();
    check("push_ack_drop", 32'(bus.PUSH_ACK), 32'd0);
    check("hold_dat", bus.POP_DAT, 32'd3);

    // Pop three times back-to-back
    bus.POP_STB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pop%0d_dat", i + 1), bus.POP_DAT, 32'(3 - i));
      tick();
      check($sformatf("pop%0d_ack", i + 1), 32'(bus.POP_ACK), 32'd1);
    end
    idle();
    check("pop_empty_dat", bus.POP_DAT, 32'd0);
    tick();
    check("pop_ack_drop", 32'(bus.POP_ACK), 32'd0);

    // Push 17 words into DEPTH=16
    bus.PUSH_STB = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      bus.PUSH_DAT = 32'(100 + k);
      tick();
      check($sformatf("fill%0d_ack", k), 32'(bus.PUSH_ACK), (k <= 16) ? 32'd1 : 32'd0);
    end
    idle();
    check("full_top", bus.POP_DAT, 32'd116);
`ifdef STACK_STATUS_EN
    check("full_flag", 32'(FULL), 32'd1);
    check("full_level", 32'(LEVEL), 32'd16);
`endif
    bus.POP_STB = 1'b1;
    for (int k = 16; k >= 1; k--) begin
      check($sformatf("drain%0d_dat", k), bus.POP_DAT, 32'(100 + k));
      tick();
      check($sformatf("drain%0d_ack", k), 32'(bus.POP_ACK), 32'd1);
    end
    idle();
    check("drain_empty", bus.POP_DAT, 32'd0);
    tick();

    // Simultaneous strobes on stack [4]
    bus.PUSH_STB = 1'b1;
    bus.PUSH_DAT = 32'(OP_DIV);
    tick();
    bus.POP_STB  = 1'b1;
    bus.PUSH_DAT = 32'd2;
    tick();
    idle();
    check("swap_push_ack", 32'(bus.PUSH_ACK), 32'd1);
    check("swap_pop_ack", 32'(bus.POP_ACK), 32'd1);
    check("swap_top", bus.POP_DAT, 32'd2);
    bus.POP_STB = 1'b1;
    tick();
    idle();
    check("swap_depth1", bus.POP_DAT, 32'd0);

    // Simultaneous strobes on empty stack
    bus.PUSH_STB = 1'b1;
    bus.POP_STB  = 1'b1;
    bus.PUSH_DAT = 32'd3;
    tick();
    idle();
    check("both_empty_push_ack", 32'(bus.PUSH_ACK), 32'd1);
    check("both_empty_pop_ack", 32'(bus.POP_ACK), 32'd0);
    check("both_empty_top", bus.POP_DAT, 32'd3);
    bus.POP_STB = 1'b1;
    tick();
    idle();
    check("both_empty_drain", bus.POP_DAT, 32'd0);

    // Reset after pushing 2 words, with a push on the reset edge
    bus.PUSH_STB = 1'b1;
    bus.PUSH_DAT = 32'd7;
    tick();
    bus.PUSH_DAT = 32'd8;
    tick();
    check("pre_rst_top", bus.POP_DAT, 32'd8);
    bus.PUSH_DAT = 32'd9;
    RST = 1'b0;
    tick();
    check("rst2_pop_dat", bus.POP_DAT, 32'd0);
    check("rst2_push_ack", 32'(bus.PUSH_ACK), 32'd0);
    check("rst2_pop_ack", 32'(bus.POP_ACK), 32'd0);
`ifdef STACK_STATUS_EN
    check("rst2_empty", 32'(EMPTY), 32'd1);
    check("rst2_level", 32'(LEVEL), 32'd0);
`endif
    RST = 1'b1;
    idle();
    tick();
    check("post_rst_idle", bus.POP_DAT, 32'd0);
    bus.PUSH_STB = 1'b1;
    bus.PUSH_DAT = 32'd5;
    tick();
    idle();
    check("post_rst_push", bus.POP_DAT, 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_lifo_stack

// File: doc/lifo_stack.md
# lifo_stack

Parameterised synchronous LIFO stack with strobe/acknowledge push and pop ports. It serves as the operator stack in the infix-to-postfix converter, storing operator codes (1 `+`, 2 `-`, 3 `*`, 4 `/`) and returning them in reverse order. It holds up to DEPTH words of WIDTH bits, with single-cycle push/pop and a combinational top-of-stack view.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 16: maximum number of stored words; must be ≥ 2.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- PUSH_STB  in  1  push request, sampled on the rising edge.
- PUSH_DAT  in  WIDTH  word to push, sampled with PUSH_STB.
- POP_STB  in  1  pop request, sampled on the rising edge.
- POP_DAT  out  WIDTH  combinational top-of-stack: mem[sp-1], or 0 when empty.
- POP_ACK  out  1  registered one-cycle pulse: the previous edge accepted a pop.
- PUSH_ACK  out  1  registered one-cycle pulse: the previous edge accepted a push.

## Operation
- State: storage array mem[0..DEPTH-1] and stack pointer sp in the range 0..DEPTH. sp is ceil(log2(DEPTH+1)) bits wide.
- Empty when sp == 0. Full when sp == DEPTH.
- Push only, not full: mem[sp] <= PUSH_DAT, sp <= sp+1, PUSH_ACK <= 1.
- Push only, full: request dropped. sp and mem are unchanged and PUSH_ACK stays 0.
- Pop only, not empty: sp <= sp-1, POP_ACK <= 1. The consumer takes the word from POP_DAT in the same cycle POP_STB is high, or before asserting it.
- Pop only, empty: ignored. POP_ACK stays 0 and POP_DAT stays 0.
- Push and pop together, not empty: mem[sp-1] <= PUSH_DAT (the top is replaced), sp unchanged, both acks pulse.
- Push and pop together, empty: treated as push only; POP_ACK stays 0.
- No strobe: all state holds and both acks are 0.
- POP_DAT updates combinationally from sp and mem whenever either changes.

## Timing
- Reset: takes effect on the first rising edge with RST=0. It sets sp=0 and POP_ACK=PUSH_ACK=0. POP_DAT therefore reads 0. mem contents are not cleared.
- Reset mid-operation: any strobe present on the reset edge is discarded.
- Latency: an accepted push is visible on POP_DAT immediately after the accepting edge.
- Acks go high for exactly one cycle after each accepting edge.
- Throughput: one push and/or pop per cycle. Back-to-back strobes are allowed with no gap.
- Strobes are level-sampled. A strobe held for N cycles performs N operations; requesters pulse strobes for one cycle per operation.

## Configuration
- Macro STACK_STATUS_EN.
- Defined: adds output ports FULL (1 bit), EMPTY (1 bit) and LEVEL (ceil(log2(DEPTH+1)) bits), all decoded combinationally from sp. Their reset values are FULL=0, EMPTY=1, LEVEL=0.
- Undefined: none of these ports exist, and the port list is exactly the list in Interface.

## Structure
- Package stack_pkg contains:
  - the default WIDTH and DEPTH constants;
  - the operator code enum (OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4) shared with the converter.
- One sub-module, stack_mem: a DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
- The top level holds the pointer, the accept logic and the ack registers.

## Test plan
- Reset with no strobes:
  - POP_DAT=0, both acks 0, pop ignored (POP_ACK stays 0).
- Push 1, 2, 3 on consecutive cycles:
  - PUSH_ACK is high for 3 cycles.
  - POP_DAT reads 1, then 2, then 3 after each edge.
- Pop three times back-to-back:
  - POP_DAT reads 3, 2, 1 before each edge.
  - Three POP_ACK pulses; the stack is then empty and POP_DAT=0.
- Push 17 words into DEPTH=16:
  - The 17th push gets no PUSH_ACK.
  - POP_DAT reads the 16th word; pops return words 16..1.
- Simultaneous strobes:
  - Push+pop on stack [4]: top becomes the pushed word (e.g. 2), depth unchanged, both acks pulse.
  - Push+pop on an empty stack: a push of 3 only.
- Reset after pushing 2 words:
  - sp=0, POP_DAT=0, no acks.
  - With STACK_STATUS_EN defined: EMPTY=1 and LEVEL=0.
